filter_output_arbiter: RTL
==========================

# filter_output_arbiter

Round-robin read arbiter for the per-filter pair buffers in the force-evaluation front end. Each cycle it picks at most one non-empty filter buffer, issues a one-hot read enable, and one cycle later presents the matching one-hot select and readout-valid to the pair selection stage. It is the issuing end of that select interface. It throttles issue against a credit count of free slots in the downstream pair FIFO and supports a flush handshake used at the end of a home-cell pass.

## Interface
- NUM_FILTERS, default 8: number of filter buffers arbitrated (from MD_pkg).
- CREDITS, default 16: downstream pair FIFO depth; initial and maximum credit count.
- CNT_WIDTH, default 32: width of the issued-pair counter.
- Clocking and reset: one clock; reset is synchronous and active-low.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- i_enable  in  1  arbitration allowed while high.
- i_filter_buffer_empty  in  NUM_FILTERS  per-filter empty flag; already reflects every read enable issued up to the previous cycle.
- i_credit_return  in  1  one pulse per pair popped from the downstream FIFO.
- i_flush  in  1  request to stop issuing and drain; level, sampled in RUN.
- o_filter_buffer_rd_en  out  NUM_FILTERS  one-hot or zero read enable to the filter buffers.
- o_filter_output_arb_result  out  NUM_FILTERS  last cycle's rd_en, aligned with buffer readout data.
- o_filter_buffer_readout_valid  out  NUM_FILTERS  last cycle's rd_en, as per-filter valid.
- o_credits  out  $clog2(CREDITS+1)  current credit count.
- o_pairs_issued  out  CNT_WIDTH  pairs granted since reset; wraps.
- o_flush_done  out  1  one-cycle pulse when a drain completes.
- o_credit_err  out  1  sticky; credit returned while count already equals CREDITS.

## Operation
- FSM states:
  - RUN: arbitrate. i_flush=1 moves to DRAIN; no grant is issued in the cycle i_flush is sampled.
  - DRAIN: no grants. Move to DONE when the stage-1 register is zero and credits==CREDITS.
  - DONE: o_flush_done=1 for exactly one cycle, then return to RUN. i_flush is ignored in DONE.
- Request vector: ~i_filter_buffer_empty.
- Grant condition: state==RUN, i_enable=1, i_flush=0, credits>0, and request nonzero.
- Round-robin:
  - Pointer last holds the index of the most recent grant; reset value NUM_FILTERS-1.
  - Search order is last+1, last+2, … modulo NUM_FILTERS; the first requester wins.
  - last updates only on a grant.
- o_filter_buffer_rd_en is combinational from the current-cycle search and registered state. It is zero when there is no grant.
- Stage-1 register: captures rd_en every cycle. It drives both o_filter_output_arb_result and o_filter_buffer_readout_valid, so these are always equal and one-hot or zero.
- Credits:
  - next = credits - grant + i_credit_return.
  - A simultaneous grant and return leaves the count unchanged.
  - A return when credits==CREDITS with no same-cycle grant does not increment; it sets o_credit_err, which is cleared only by reset.
- o_pairs_issued increments by 1 per grant and wraps from 2^CNT_WIDTH-1 to 0.

## Timing
- Reset (rst_n=0 at an edge) forces the following; in-flight state is discarded mid-operation:
  - State RUN, last=NUM_FILTERS-1, credits=CREDITS.
  - Stage-1 register = 0, so arb_result=0 and readout_valid=0.
  - o_pairs_issued=0, o_flush_done=0, o_credit_err=0.
  - rd_en=0 for the whole reset cycle.
- Latency:
  - Grant in cycle t drives rd_en in cycle t.
  - arb_result and readout_valid appear in cycle t+1, coincident with the 1-cycle buffer readout.
  - The pair selection stage registers them at the end of t+1.
- Throughput: one grant per cycle when requests and credits allow.
- Credit zero: rd_en=0 in that cycle. A return in cycle t allows a grant in cycle t+1; it does not allow one in cycle t.
- Flush:
  - Minimum i_flush to o_flush_done is 2 cycles, when no pair is in flight and credits are full.
  - Otherwise o_flush_done follows the last credit return by 1 cycle.

## Test plan
- Reset, then request vector 8'b1111_1111 held with credits ample:
  - rd_en sequence is 0x01, 0x02, …, 0x80, 0x01.
  - arb_result shows the same sequence one cycle later.
  - o_pairs_issued=9 after 9 grants.
- Request vector 8'b0010_0100 (filters 2 and 5) after last=2: grant 5, then 2, then 5; filters without a request are never granted.
- CREDITS=4, no returns, all filters requesting:
  - Exactly 4 grants, then rd_en=0 and o_credits=0.
  - One return pulse gives exactly one further grant, on the following cycle.
- Credits=CREDITS, i_credit_return pulses with no grant: o_credits stays at CREDITS and o_credit_err goes high and stays high.
- 2 grants outstanding, i_flush asserted:
  - No further grants.
  - o_flush_done pulses 1 cycle after the second credit returns.
  - Arbitration then resumes in RUN.
- rst_n driven low mid-stream with credits=1 and stage-1 nonzero: the next cycle shows all reset values, and the first grant after release goes to filter 0.

Source files
------------

// File: rtl/filter_output_arbiter.sv
// Round-robin read arbiter for the per-filter pair buffers, throttled by
// downstream FIFO credits, with a flush/drain handshake for end-of-pass.
module filter_output_arbiter #(
  parameter int NUM_FILTERS = 8,
  parameter int CREDITS     = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_enable,
  input  logic [NUM_FILTERS-1:0]         i_filter_buffer_empty,
  input  logic                           i_credit_return,
  input  logic                           i_flush,
  output logic [NUM_FILTERS-1:0]         o_filter_buffer_rd_en,
  output logic [NUM_FILTERS-1:0]         o_filter_output_arb_result,
  output logic [NUM_FILTERS-1:0]         o_filter_buffer_readout_valid,
  output logic [$clog2(CREDITS+1)-1:0]   o_credits,
  output logic [CNT_WIDTH-1:0]           o_pairs_issued,
  output logic                           o_flush_done,
  output logic                           o_credit_err
);

  localparam int IW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [IW-1:0]          last_reg, last_next;
  logic [CW-1:0]          credits_reg, credits_next;
  logic [NUM_FILTERS-1:0] stage1_reg;
  logic [CNT_WIDTH-1:0]   pairs_reg;
  logic                   err_reg, err_set;

  logic [NUM_FILTERS-1:0] req;
  logic                   found;
  logic [IW-1:0]          pick;
  int                     idx;
  logic                   grant;
  logic [NUM_FILTERS-1:0] rd_en;

  assign req = ~i_filter_buffer_empty;

  // Scan from the slot after the last grant, wrapping; first requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_FILTERS; k++) begin
      idx = (int'(last_reg) + k) % NUM_FILTERS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // rst_n gates the grant so no read enable escapes during a reset cycle.
  assign grant = rst_n && (state_reg == RUN) && i_enable && !i_flush &&
                 (credits_reg != '0) && found;

  always_comb begin
    rd_en = '0;
    if (grant) rd_en[pick] = 1'b1;
  end

  always_comb begin
    credits_next = credits_reg;
    err_set      = 1'b0;
    if (grant && !i_credit_return) begin
      credits_next = credits_reg - CW'(1);
    end else if (!grant && i_credit_return) begin
      if (credits_reg == CW'(CREDITS)) err_set = 1'b1;
      else credits_next = credits_reg + CW'(1);
    end
  end

  assign last_next = grant ? pick : last_reg;

  // Drain completes on the cycle the final credit arrives, so done pulses
  // one cycle after that return.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (i_flush) state_next = DRAIN;
      DRAIN:   if ((stage1_reg == '0) && (credits_next == CW'(CREDITS)))
                 state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      last_reg    <= IW'(NUM_FILTERS - 1);
      credits_reg <= CW'(CREDITS);
      stage1_reg  <= '0;
      pairs_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      credits_reg <= credits_next;
      stage1_reg  <= rd_en;
      if (grant) pairs_reg <= pairs_reg + CNT_WIDTH'(1);
      if (err_set) err_reg <= 1'b1;
    end
  end

  assign o_filter_buffer_rd_en         = rd_en;
  assign o_filter_output_arb_result    = stage1_reg;
  assign o_filter_buffer_readout_valid = stage1_reg;
  assign o_credits                     = credits_reg;
  assign o_pairs_issued                = pairs_reg;
  assign o_flush_done                  = (state_reg == DONE);
  assign o_credit_err                  = err_reg;

endmodule
